// File: rtl/trigger_selector_mc_pkg.sv
// Shared defaults and trigger mode codes for the multi-channel trigger selector.
package selector_config;

  localparam int DEF_TYPE_W   = 2;
  localparam int DEF_TYPE_LSB = 64;
  localparam int DEF_RFDC_W   = 128;
  localparam int DEF_TDATA_W  = 256;

  localparam logic [DEF_TYPE_W-1:0] MODE_HARDWARE    = 2'd0;
  localparam logic [DEF_TYPE_W-1:0] MODE_EXTERNAL    = 2'd1;
  localparam logic [DEF_TYPE_W-1:0] MODE_SOFTWARE    = 2'd2;
  localparam logic [DEF_TYPE_W-1:0] MODE_COINCIDENCE = 2'd3;

endpackage

// File: rtl/trigger_selector_mc_if.sv
// Per-channel stream bundle between the framers, the selector and the packet builders.
interface trigger_selector_mc_if #(
  parameter int N_CH    = 4,
  parameter int TDATA_W = 256,
  parameter int RFDC_W  = 128
);

  logic [N_CH-1:0]         S_AXIS_TVALID;
  logic [N_CH*TDATA_W-1:0] S_AXIS_TDATA;
  logic [N_CH*RFDC_W-1:0]  H_GAIN_TDATA_IN;
  logic [N_CH-1:0]         M_AXIS_TVALID;
  logic [N_CH*TDATA_W-1:0] M_AXIS_TDATA;
  logic [N_CH*RFDC_W-1:0]  H_GAIN_TDATA;

  modport master (
    output S_AXIS_TVALID, S_AXIS_TDATA, H_GAIN_TDATA_IN,
    input  M_AXIS_TVALID, M_AXIS_TDATA, H_GAIN_TDATA
  );

  modport slave (
    input  S_AXIS_TVALID, S_AXIS_TDATA, H_GAIN_TDATA_IN,
    output M_AXIS_TVALID, M_AXIS_TDATA, H_GAIN_TDATA
  );

endinterface

// File: rtl/trigger_selector_mc_gate.sv
// Per-channel trigger gate: opens for gate_len cycles after the most recent trigger.
module trigger_gate #(
  parameter int GATE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic              clear,
  input  logic [GATE_W-1:0] gate_len,
  output logic              open
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OPEN = 1'b1;

  logic [0:0]        state;
  logic [GATE_W-1:0] cnt;

  // clear beats trig so an abort can never be undone by a trigger in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (clear) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (trig) begin
      state <= ST_OPEN;
      cnt   <= gate_len - GATE_W'(1);
    end else if (state == ST_OPEN) begin
      if (cnt != '0) begin
        cnt <= cnt - GATE_W'(1);
      end else begin
        state <= ST_IDLE;
      end
    end
  end

  assign open = (state == ST_OPEN);

endmodule

// File: rtl/trigger_selector_mc.sv
// Multi-channel trigger selector: picks each channel's valid source, stamps its trigger type into TDATA.
module trigger_selector_mc
  import selector_config::*;
#(
  parameter int N_CH        = 4,
  parameter int RFDC_W      = DEF_RFDC_W,
  parameter int TDATA_W     = DEF_TDATA_W,
  parameter int TYPE_W      = DEF_TYPE_W,
  parameter int TYPE_LSB    = DEF_TYPE_LSB,
  parameter int SYNC_STAGES = 2,
  parameter int GATE_W      = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   SET_CONFIG,
  input  logic                   STOP,
  input  logic [N_CH*TYPE_W-1:0] TRIGGER_TYPE,
  input  logic [GATE_W-1:0]      GATE_LENGTH,
  input  logic                   EXTERNAL_TRIGGER,
  input  logic                   SW_TRIGGER,
  trigger_selector_mc_if.slave   axis,
  output logic [N_CH-1:0]        GATE_OPEN
);

  logic [SYNC_STAGES-1:0]        ext_sync;
  logic                          ext_last;
  logic                          ext_pulse;
  logic [TYPE_W-1:0]             cfg_type [N_CH];
  logic [GATE_W-1:0]             gate_len;
  logic [N_CH-1:0]               trig;
  logic [N_CH-1:0]               raw_valid;
  logic [N_CH-1:0]               gate_open;
  logic [N_CH-1:0]               valid_s1;
  logic [N_CH-1:0]               valid_s2;
  logic [N_CH-1:0][TDATA_W-1:0]  typed_data;
  logic [N_CH-1:0][TDATA_W-1:0]  data_s1;
  logic [N_CH-1:0][TDATA_W-1:0]  data_s2;
  logic [N_CH*RFDC_W-1:0]        hgain_s1;
  logic [N_CH*RFDC_W-1:0]        hgain_s2;
  logic                          abort;

  assign abort = SET_CONFIG | STOP;

  // ext_pulse is registered, so a gate opens SYNC_STAGES+1 edges after the level is first sampled
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ext_sync  <= '0;
      ext_last  <= 1'b0;
      ext_pulse <= 1'b0;
    end else begin
      ext_sync  <= {ext_sync[SYNC_STAGES-2:0], EXTERNAL_TRIGGER};
      ext_last  <= ext_sync[SYNC_STAGES-1];
      ext_pulse <= ext_sync[SYNC_STAGES-1] & ~ext_last;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int c = 0; c < N_CH; c++) cfg_type[c] <= TYPE_W'(MODE_HARDWARE);
      gate_len <= GATE_W'(1);
    end else if (SET_CONFIG) begin
      for (int c = 0; c < N_CH; c++) cfg_type[c] <= TRIGGER_TYPE[c*TYPE_W +: TYPE_W];
      gate_len <= (GATE_LENGTH == '0) ? GATE_W'(1) : GATE_LENGTH;
    end
  end

  always_comb begin
    trig       = '0;
    raw_valid  = '0;
    typed_data = axis.S_AXIS_TDATA;
    for (int c = 0; c < N_CH; c++) begin
      typed_data[c][TYPE_LSB +: TYPE_W] = cfg_type[c];
      case (cfg_type[c])
        TYPE_W'(MODE_EXTERNAL): begin
          trig[c]      = ext_pulse;
          raw_valid[c] = gate_open[c];
        end
        TYPE_W'(MODE_SOFTWARE): begin
          trig[c]      = SW_TRIGGER;
          raw_valid[c] = gate_open[c];
        end
        TYPE_W'(MODE_COINCIDENCE): begin
          trig[c]      = ext_pulse;
          raw_valid[c] = axis.S_AXIS_TVALID[c] & gate_open[c];
        end
        default: begin
          raw_valid[c] = axis.S_AXIS_TVALID[c];
        end
      endcase
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_gate
    trigger_gate #(.GATE_W(GATE_W)) u_gate (
      .clk      (ACLK),
      .rst_n    (ARESETN),
      .trig     (trig[c]),
      .clear    (abort),
      .gate_len (gate_len),
      .open     (gate_open[c])
    );
  end

  // STOP only clears stage 1, which leaves one cycle of slack; SET_CONFIG flushes both stages
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      valid_s1 <= '0;
      valid_s2 <= '0;
      data_s1  <= '0;
      data_s2  <= '0;
      hgain_s1 <= '0;
      hgain_s2 <= '0;
    end else begin
      valid_s1 <= abort ? '0 : raw_valid;
      valid_s2 <= SET_CONFIG ? '0 : valid_s1;
      data_s1  <= typed_data;
      data_s2  <= data_s1;
      hgain_s1 <= axis.H_GAIN_TDATA_IN;
      hgain_s2 <= hgain_s1;
    end
  end

  assign axis.M_AXIS_TVALID = valid_s2;
  assign axis.M_AXIS_TDATA  = data_s2;
  assign axis.H_GAIN_TDATA  = hgain_s2;
  assign GATE_OPEN          = gate_open;

endmodule

// File: tb/tb_trigger_selector_mc.sv
// Bench for trigger_selector_mc: directed tables and sequences plus random traffic against a cycle model.
module tb_trigger_selector_mc;

  localparam int N_CH        = 4;
  localparam int TDATA_W     = 256;
  localparam int RFDC_W      = 128;
  localparam int TYPE_W      = 2;
  localparam int TYPE_LSB    = 64;
  localparam int SYNC_STAGES = 2;
  localparam int GATE_W      = 16;

  logic                   ACLK = 1'b0;
  logic                   ARESETN;
  logic                   SET_CONFIG;
  logic                   STOP;
  logic [N_CH*TYPE_W-1:0] TRIGGER_TYPE;
  logic [GATE_W-1:0]      GATE_LENGTH;
  logic                   EXTERNAL_TRIGGER;
  logic                   SW_TRIGGER;
  logic [N_CH-1:0]        GATE_OPEN;

  int checks   = 0;
  int failures = 0;

  trigger_selector_mc_if #(.N_CH(N_CH), .TDATA_W(TDATA_W), .RFDC_W(RFDC_W)) axis ();

  trigger_selector_mc #(
    .N_CH(N_CH), .RFDC_W(RFDC_W), .TDATA_W(TDATA_W), .TYPE_W(TYPE_W),
    .TYPE_LSB(TYPE_LSB), .SYNC_STAGES(SYNC_STAGES), .GATE_W(GATE_W)
  ) dut (
    .ACLK             (ACLK),
    .ARESETN          (ARESETN),
    .SET_CONFIG       (SET_CONFIG),
    .STOP             (STOP),
    .TRIGGER_TYPE     (TRIGGER_TYPE),
    .GATE_LENGTH      (GATE_LENGTH),
    .EXTERNAL_TRIGGER (EXTERNAL_TRIGGER),
    .SW_TRIGGER       (SW_TRIGGER),
    .axis             (axis),
    .GATE_OPEN        (GATE_OPEN)
  );

  always #5 ACLK = ~ACLK;

  // Reference model: gate = cycles remaining, outputs derived from one-cycle-old histories
  logic [TYPE_W-1:0]  mType [N_CH];
  int                 mLen;
  int                 rem [N_CH];
  bit                 extQ [$];
  bit                 rawPrev [N_CH];
  bit                 killPrev;
  bit                 expValid [N_CH];
  logic [TDATA_W-1:0] dPrev [N_CH];
  logic [TDATA_W-1:0] dOut [N_CH];
  logic [RFDC_W-1:0]  hPrev [N_CH];
  logic [RFDC_W-1:0]  hOut [N_CH];

  typedef struct {
    logic [N_CH*TYPE_W-1:0] types;
    int                     len;
    int                     expGate;
  } vec_t;

  vec_t vecs [6];

  task automatic modelReset();
    for (int c = 0; c < N_CH; c++) begin
      mType[c] = '0; rem[c] = 0; rawPrev[c] = 0; expValid[c] = 0;
      dPrev[c] = '0; dOut[c] = '0; hPrev[c] = '0; hOut[c] = '0;
    end
    mLen = 1;
    killPrev = 0;
    extQ.delete();
    repeat (SYNC_STAGES + 2) extQ.push_back(1'b0);
  endtask

  task automatic modelEdge();
    bit pulse, isOpen, raw, trig, tv;
    logic [TDATA_W-1:0] d;
    pulse = extQ[1] && !extQ[0];
    for (int c = 0; c < N_CH; c++) begin
      isOpen = rem[c] > 0;
      tv = axis.S_AXIS_TVALID[c];
      case (int'(mType[c]))
        1:       begin raw = isOpen;       trig = pulse;      end
        2:       begin raw = isOpen;       trig = SW_TRIGGER; end
        3:       begin raw = tv && isOpen; trig = pulse;      end
        default: begin raw = tv;           trig = 0;          end
      endcase
      expValid[c] = rawPrev[c] && !killPrev && !SET_CONFIG;
      rawPrev[c] = raw;
      dOut[c] = dPrev[c];
      d = axis.S_AXIS_TDATA[c*TDATA_W +: TDATA_W];
      d[TYPE_LSB +: TYPE_W] = mType[c];
      dPrev[c] = d;
      hOut[c] = hPrev[c];
      hPrev[c] = axis.H_GAIN_TDATA_IN[c*RFDC_W +: RFDC_W];
      if (SET_CONFIG || STOP) rem[c] = 0;
      else if (trig) rem[c] = mLen;
      else if (rem[c] > 0) rem[c] = rem[c] - 1;
    end
    killPrev = SET_CONFIG || STOP;
    if (SET_CONFIG) begin
      for (int c = 0; c < N_CH; c++) mType[c] = TRIGGER_TYPE[c*TYPE_W +: TYPE_W];
      mLen = (GATE_LENGTH == 0) ? 1 : int'(GATE_LENGTH);
    end
    extQ.push_back(EXTERNAL_TRIGGER);
    void'(extQ.pop_front());
  endtask

  task automatic checkEq(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic [N_CH-1:0] eV, eG;
    for (int c = 0; c < N_CH; c++) begin
      eV[c] = expValid[c];
      eG[c] = rem[c] > 0;
      checkEq($sformatf("tdata_ch%0d", c), axis.M_AXIS_TDATA[c*TDATA_W +: TDATA_W], dOut[c]);
      checkEq($sformatf("hgain_ch%0d", c), 256'(axis.H_GAIN_TDATA[c*RFDC_W +: RFDC_W]), 256'(hOut[c]));
    end
    checkEq("m_valid", 256'(axis.M_AXIS_TVALID), 256'(eV));
    checkEq("gate_open", 256'(GATE_OPEN), 256'(eG));
  endtask

  task automatic applyStimulus();
    for (int w = 0; w < N_CH*TDATA_W/32; w++) axis.S_AXIS_TDATA[w*32 +: 32] = $urandom;
    for (int w = 0; w < N_CH*RFDC_W/32; w++) axis.H_GAIN_TDATA_IN[w*32 +: 32] = $urandom;
    @(posedge ACLK);
    modelEdge();
    @(negedge ACLK);
    checkOutput();
  endtask

  task automatic configure(input logic [N_CH*TYPE_W-1:0] types, input int len);
    SET_CONFIG = 1'b1;
    TRIGGER_TYPE = types;
    GATE_LENGTH = GATE_W'(len);
    applyStimulus();
    SET_CONFIG = 1'b0;
    repeat (2) applyStimulus();
  endtask

  function automatic logic [TYPE_W-1:0] typeField(input int c);
    return axis.M_AXIS_TDATA[c*TDATA_W + TYPE_LSB +: TYPE_W];
  endfunction

  initial begin
    int cnt, first;

    vecs[0] = '{types: 8'hAA, len: 0, expGate: 1};
    vecs[1] = '{types: 8'hAA, len: 1, expGate: 1};
    vecs[2] = '{types: 8'hAA, len: 3, expGate: 3};
    vecs[3] = '{types: 8'hAA, len: 7, expGate: 7};
    vecs[4] = '{types: 8'h00, len: 5, expGate: 0};
    vecs[5] = '{types: 8'h55, len: 4, expGate: 0};

    ARESETN = 1'b0; SET_CONFIG = 0; STOP = 0; TRIGGER_TYPE = '0; GATE_LENGTH = '0;
    EXTERNAL_TRIGGER = 0; SW_TRIGGER = 0;
    axis.S_AXIS_TVALID = '0; axis.S_AXIS_TDATA = '0; axis.H_GAIN_TDATA_IN = '0;
    modelReset();
    #23;
    @(negedge ACLK);
    ARESETN = 1'b1;
    checkEq("reset_valid", 256'(axis.M_AXIS_TVALID), 256'(0));
    checkEq("reset_gate", 256'(GATE_OPEN), 256'(0));

    // Hardware mode pass-through with two cycles of latency
    axis.S_AXIS_TVALID = 4'b0101;
    applyStimulus();
    axis.S_AXIS_TVALID = 4'b0000;
    checkEq("hw_t1", 256'(axis.M_AXIS_TVALID), 256'(0));
    applyStimulus();
    checkEq("hw_t2", 256'(axis.M_AXIS_TVALID), 256'(4'b0101));
    for (int c = 0; c < N_CH; c++) checkEq($sformatf("hw_type%0d", c), 256'(typeField(c)), 256'(0));
    applyStimulus();
    checkEq("hw_t3", 256'(axis.M_AXIS_TVALID), 256'(0));

    // Table: single software pulse, ch0 gate length
    foreach (vecs[i]) begin
      configure(vecs[i].types, vecs[i].len);
      SW_TRIGGER = 1'b1;
      applyStimulus();
      SW_TRIGGER = 1'b0;
      cnt = int'(GATE_OPEN[0]);
      repeat (11) begin
        applyStimulus();
        cnt += int'(GATE_OPEN[0]);
      end
      checkEq($sformatf("table%0d_gate", i), 256'(cnt), 256'(vecs[i].expGate));
    end

    // External gate on ch1, level held for 20 cycles
    configure(8'h04, 5);
    EXTERNAL_TRIGGER = 1'b1;
    cnt = 0; first = -1;
    for (int k = 0; k < 30; k++) begin
      if (k == 20) EXTERNAL_TRIGGER = 1'b0;
      applyStimulus();
      if (axis.M_AXIS_TVALID[1]) begin
        if (first < 0) begin
          first = k;
          checkEq("ext_type", 256'(typeField(1)), 256'(1));
        end
        cnt++;
      end
    end
    checkEq("ext_count", 256'(cnt), 256'(5));
    checkEq("ext_latency", 256'(first), 256'(SYNC_STAGES + 3));

    // Software retrigger on ch2
    configure(8'h20, 4);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      SW_TRIGGER = (k == 0 || k == 2);
      applyStimulus();
      cnt += int'(GATE_OPEN[2]);
    end
    SW_TRIGGER = 1'b0;
    checkEq("retrig_gate", 256'(cnt), 256'(6));
    configure(8'h20, 0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      SW_TRIGGER = (k == 0);
      applyStimulus();
      cnt += int'(GATE_OPEN[2]);
    end
    SW_TRIGGER = 1'b0;
    checkEq("len0_gate", 256'(cnt), 256'(1));

    // Coincidence on ch3 with continuous hardware valid
    configure(8'hC0, 3);
    axis.S_AXIS_TVALID = 4'b1000;
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      EXTERNAL_TRIGGER = (k < 4);
      applyStimulus();
      cnt += int'(axis.M_AXIS_TVALID[3]);
    end
    checkEq("coinc_count", 256'(cnt), 256'(3));
    cnt = 0;
    repeat (15) begin
      applyStimulus();
      cnt += int'(axis.M_AXIS_TVALID[3]);
    end
    checkEq("coinc_noext", 256'(cnt), 256'(0));
    axis.S_AXIS_TVALID = '0;

    // STOP during an open gate on ch0
    configure(8'h02, 10);
    SW_TRIGGER = 1'b1;
    applyStimulus();
    SW_TRIGGER = 1'b0;
    repeat (3) applyStimulus();
    checkEq("stop_pre_valid", 256'(axis.M_AXIS_TVALID[0]), 256'(1));
    STOP = 1'b1;
    applyStimulus();
    STOP = 1'b0;
    checkEq("stop_gate", 256'(GATE_OPEN[0]), 256'(0));
    cnt = int'(axis.M_AXIS_TVALID[0]);
    repeat (5) begin
      applyStimulus();
      cnt += int'(axis.M_AXIS_TVALID[0]);
    end
    checkEq("stop_slack", 256'(cnt), 256'(1));

    // SET_CONFIG together with SW_TRIGGER while ch0 is streaming
    SW_TRIGGER = 1'b1;
    applyStimulus();
    SW_TRIGGER = 1'b0;
    repeat (2) applyStimulus();
    SET_CONFIG = 1'b1; SW_TRIGGER = 1'b1; TRIGGER_TYPE = 8'hAA; GATE_LENGTH = 16'd10;
    applyStimulus();
    SET_CONFIG = 1'b0; SW_TRIGGER = 1'b0;
    checkEq("cfg_valid0", 256'(axis.M_AXIS_TVALID), 256'(0));
    checkEq("cfg_gate", 256'(GATE_OPEN), 256'(0));
    applyStimulus();
    checkEq("cfg_valid1", 256'(axis.M_AXIS_TVALID), 256'(0));
    applyStimulus();
    for (int c = 0; c < N_CH; c++) checkEq($sformatf("cfg_type%0d", c), 256'(typeField(c)), 256'(2));
    cnt = 0;
    repeat (8) begin
      applyStimulus();
      cnt += $countones(GATE_OPEN);
    end
    checkEq("cfg_no_gate", 256'(cnt), 256'(0));

    // Random traffic against the model
    for (int k = 0; k < 2500; k++) begin
      SET_CONFIG = ($urandom_range(39) == 0);
      TRIGGER_TYPE = N_CH*TYPE_W'($urandom);
      GATE_LENGTH = GATE_W'($urandom_range(7));
      STOP = ($urandom_range(49) == 0);
      SW_TRIGGER = ($urandom_range(11) == 0);
      if ($urandom_range(9) == 0) EXTERNAL_TRIGGER = ~EXTERNAL_TRIGGER;
      axis.S_AXIS_TVALID = N_CH'($urandom);
      applyStimulus();
    end
    SET_CONFIG = 0; STOP = 0; SW_TRIGGER = 0; EXTERNAL_TRIGGER = 0; axis.S_AXIS_TVALID = '0;
    repeat (6) applyStimulus();

    // Asynchronous reset in the middle of a long ch1 gate
    configure(8'h04, 100);
    EXTERNAL_TRIGGER = 1'b1;
    axis.S_AXIS_TVALID = 4'b1111;
    repeat (8) applyStimulus();
    checkEq("rst_pre_gate", 256'(GATE_OPEN[1]), 256'(1));
    @(posedge ACLK);
    modelEdge();
    #2;
    ARESETN = 1'b0;
    #1;
    checkEq("rst_valid", 256'(axis.M_AXIS_TVALID), 256'(0));
    checkEq("rst_gate", 256'(GATE_OPEN), 256'(0));
    checkEq("rst_tdata", axis.M_AXIS_TDATA[255:0], 256'(0));
    checkEq("rst_hgain", 256'(axis.H_GAIN_TDATA[RFDC_W-1:0]), 256'(0));
    modelReset();
    EXTERNAL_TRIGGER = 1'b0;
    axis.S_AXIS_TVALID = '0;
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    axis.S_AXIS_TVALID = 4'b1111;
    applyStimulus();
    axis.S_AXIS_TVALID = '0;
    applyStimulus();
    checkEq("post_rst_hw", 256'(axis.M_AXIS_TVALID), 256'(4'b1111));
    for (int c = 0; c < N_CH; c++) checkEq($sformatf("post_rst_type%0d", c), 256'(typeField(c)), 256'(0));
    repeat (3) applyStimulus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trigger_selector_mc.md
Name: trigger_selector_mc

Overview:
- Multi-channel, parametrised successor of the single-channel trigger selector.
- Sits between the per-channel trigger/timestamp framers and the downstream packet builders.
- Per channel, selects the output-valid source (hardware self-trigger, external trigger gate, software trigger gate, or hardware-AND-external coincidence) and stamps the active trigger type into the channel's TDATA.
- External and software triggers open a per-channel gate of programmable length; TDATA and H_GAIN data are delayed by a fixed 2-cycle pipeline.

Parameters:
N_CH, 4, number of ADC channels
RFDC_W, 128, raw RFDC sample width per channel (H_GAIN path)
TDATA_W, 256, full per-channel S_AXIS_TDATA width (RFDC data + trigger info + timestamp + trigger config)
TYPE_W, 2, trigger type field width
TYPE_LSB, 64, bit position of the trigger type field inside per-channel TDATA
SYNC_STAGES, 2, synchroniser depth for EXTERNAL_TRIGGER (≥2)
GATE_W, 16, gate length counter width

Ports:
ACLK  in  1  system clock
ARESETN  in  1  asynchronous active-low reset
SET_CONFIG  in  1  load TRIGGER_TYPE/GATE_LENGTH, abort open gates
STOP  in  1  suppress all output valids, abort open gates
TRIGGER_TYPE  in  N_CH*TYPE_W  per-channel mode, sampled on SET_CONFIG
GATE_LENGTH  in  GATE_W  gate length in cycles, sampled on SET_CONFIG
EXTERNAL_TRIGGER  in  1  asynchronous external trigger level
SW_TRIGGER  in  1  single-cycle software trigger pulse, ACLK domain
S_AXIS_TVALID  in  N_CH  per-channel hardware trigger valid
S_AXIS_TDATA  in  N_CH*TDATA_W  per-channel framed data, channel 0 in LSBs
H_GAIN_TDATA_IN  in  N_CH*RFDC_W  per-channel high-gain samples
M_AXIS_TVALID  out  N_CH  per-channel output valid
M_AXIS_TDATA  out  N_CH*TDATA_W  TDATA with the trigger type field replaced
H_GAIN_TDATA  out  N_CH*RFDC_W  delayed high-gain samples
GATE_OPEN  out  N_CH  per-channel gate status, for debug/status registers

Behaviour:
- Mode codes (package): HARDWARE=0, EXTERNAL=1, SOFTWARE=2, COINCIDENCE=3.
- Reset (ARESETN=0, asynchronous):
  - all config registers → HARDWARE; gate_len → 1.
  - counters, gates, valid pipeline, synchronisers and edge register → 0.
  - all outputs 0.
- Config:
  - On a SET_CONFIG cycle, latch TRIGGER_TYPE and GATE_LENGTH.
  - GATE_LENGTH=0 is stored as 1.
  - Config registers hold otherwise.
- External trigger:
  - SYNC_STAGES-flop synchroniser, then rising-edge detect gives ext_pulse, one cycle wide.
  - Latency from the first ACLK edge that samples EXTERNAL_TRIGGER high to ext_pulse = SYNC_STAGES+1 cycles.
  - A level held high produces one pulse only.
- Per-channel gate FSM, states IDLE and OPEN:
  - Trigger source: ext_pulse for EXTERNAL/COINCIDENCE, SW_TRIGGER for SOFTWARE, none for HARDWARE.
  - IDLE, trigger → OPEN, cnt=gate_len-1.
  - OPEN, cnt>0 → cnt-1.
  - OPEN, cnt==0 → IDLE, unless a trigger arrives in that cycle.
  - A trigger while OPEN (retrigger) reloads cnt=gate_len-1 and stays OPEN.
  - The gate is open for exactly gate_len consecutive cycles after the last trigger.
  - SET_CONFIG or STOP forces IDLE, cnt=0, with priority over any trigger in the same cycle.
  - GATE_OPEN = (state==OPEN).
- Raw valid per channel:
  - HARDWARE: S_AXIS_TVALID.
  - EXTERNAL/SOFTWARE: GATE_OPEN.
  - COINCIDENCE: S_AXIS_TVALID & GATE_OPEN.
- Valid pipeline, 2 stages:
  - Stage 1 loads raw valid; it is cleared if SET_CONFIG or STOP.
  - Stage 2 loads stage 1; it is cleared if SET_CONFIG.
  - M_AXIS_TVALID = stage 2.
  - Consequence: an input valid appears at the output 2 cycles later; SET_CONFIG kills outputs in the following cycle and one more; STOP kills with 1 cycle of slack.
- Data pipeline:
  - TDATA and H_GAIN are delayed 2 cycles, aligned with valid, and not reset-gated (reset only clears them).
  - In each channel's stage-1 TDATA, bits [TYPE_LSB+:TYPE_W] are replaced by the channel's latched type; other bits pass unchanged.
- Simultaneous events:
  - SET_CONFIG and STOP in the same cycle: both are applied.
  - SW_TRIGGER in a SET_CONFIG cycle is dropped.
  - The new mode takes effect from the cycle after SET_CONFIG.
- Channels are fully independent apart from the shared ext_pulse, SW_TRIGGER and gate_len.

Decomposition:
- Package selector_config: mode codes, default TYPE_W, TYPE_LSB, RFDC_W, TDATA_W.
- Sub-module trigger_gate: one per channel via generate. It contains the IDLE/OPEN FSM and GATE_W counter, with inputs trig, clear, gate_len and output open.
- Synchroniser, edge detect and pipelines stay in the top level.

Test Plan:
- Reset mid-operation: gate open on ch1 with GATE_LENGTH=100, assert ARESETN low asynchronously between clock edges → all M_AXIS_TVALID, GATE_OPEN and data go 0 immediately; after release, all channels are in HARDWARE mode.
- HARDWARE on all channels: S_AXIS_TVALID=4'b0101 for 1 cycle at cycle t → M_AXIS_TVALID=4'b0101 at t+2 only; TDATA type field reads 0 on every channel.
- EXTERNAL on ch1 with GATE_LENGTH=5: EXTERNAL_TRIGGER high for 20 cycles → exactly one gate; M_AXIS_TVALID[1] high 5 consecutive cycles, first at SYNC_STAGES+1+2 cycles after sampling; type field = 1.
- Retrigger: SOFTWARE on ch2 with GATE_LENGTH=4; SW_TRIGGER at t and t+2 → GATE_OPEN[2] high t+1..t+6 (6 cycles); GATE_LENGTH=0 loaded → a 1-cycle gate.
- COINCIDENCE on ch3, gate length 3: S_AXIS_TVALID[3] high continuously → output valid only for the 3 gated cycles (+2 latency); with no external trigger → never valid.
- STOP/SET_CONFIG abort: pulse STOP during an open gate → GATE_OPEN drops next cycle, at most 1 more valid; SET_CONFIG with SW_TRIGGER in the same cycle → no gate, outputs 0 for 2 cycles, then the new types appear in TDATA.
